// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// rtl/alu_op_sequencer.sv - multi-cycle add/sub/mul sequencer between instruction source and register file / ALU
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   instr_valid/ready      instruction handshake; instr = {op[1:0], dst, src1, src2}
//   read, read_adr1/2      register file operand read
//   aluop, alu_start       ALU operation and one-cycle start pulse
//   alu_done               ALU completion (only honoured from the second EXEC cycle)
//   write, write_adr       register file write-back
//   busy                   any state other than IDLE
//   illegal, alu_timeout   one-cycle event pulses
//   retired                count of completed write-backs (wraps)
module alu_op_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [19:0]       instr,
  output logic              read,
  output logic [ADDR_W-1:0] read_adr1,
  output logic [ADDR_W-1:0] read_adr2,
  output logic [1:0]        aluop,
  output logic              alu_start,
  input  logic              alu_done,
  output logic              write,
  output logic [ADDR_W-1:0] write_adr,
  output logic              busy,
  output logic              illegal,
  output logic              alu_timeout,
  output logic [CNT_W-1:0]  retired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ILL, S_READ, S_EXEC, S_WB} state_t;

  state_t state, next_state;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] dst_q, src1_q, src2_q;
  logic [TW-1:0]     exec_cnt;

  logic              accept, done_seen, expired;
  logic [1:0]        op_f;
  logic [ADDR_W-1:0] dst_f, src1_f, src2_f;

  logic              n_ready, n_read, n_start, n_write, n_busy, n_illegal, n_timeout;
  logic [ADDR_W-1:0] n_adr1, n_adr2, n_wadr;
  logic [1:0]        n_aluop;

  // instr_ready is high exactly in IDLE, so a transfer is IDLE & instr_valid.
  assign accept    = (state == S_IDLE) && instr_valid;
  // exec_cnt == 0 marks the first EXEC cycle, where alu_done is not trusted.
  assign done_seen = alu_done && (exec_cnt != '0);
  assign expired   = (exec_cnt == TW'(TIMEOUT - 1));

  // Outputs are registered from next_state, so the fields must come straight
  // from instr on the accepting edge and from the latches afterwards.
  assign op_f   = accept ? instr[19:18] : op_q;
  assign dst_f  = accept ? ADDR_W'(instr[17:12]) : dst_q;
  assign src1_f = accept ? ADDR_W'(instr[11:6])  : src1_q;
  assign src2_f = accept ? ADDR_W'(instr[5:0])   : src2_q;

  // State register, field latches, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      exec_cnt    <= '0;
      retired     <= '0;
      instr_ready <= 1'b1;
      read        <= 1'b0;
      read_adr1   <= '0;
      read_adr2   <= '0;
      aluop       <= '0;
      alu_start   <= 1'b0;
      write       <= 1'b0;
      write_adr   <= '0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      alu_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q   <= op_f;
        dst_q  <= dst_f;
        src1_q <= src1_f;
        src2_q <= src2_f;
      end
      exec_cnt    <= (state == S_EXEC) ? exec_cnt + 1'b1 : '0;
      if (next_state == S_WB) begin
        retired <= retired + 1'b1;
      end
      instr_ready <= n_ready;
      read        <= n_read;
      read_adr1   <= n_adr1;
      read_adr2   <= n_adr2;
      aluop       <= n_aluop;
      alu_start   <= n_start;
      write       <= n_write;
      write_adr   <= n_wadr;
      busy        <= n_busy;
      illegal     <= n_illegal;
      alu_timeout <= n_timeout;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (instr[19:18] == 2'b11) ? S_ILL : S_READ;
        end
      end
      S_ILL:  next_state = S_IDLE;
      S_READ: next_state = S_EXEC;
      S_EXEC: begin
        // A done arriving in the last allowed cycle still wins over the abort.
        if (done_seen) begin
          next_state = S_WB;
        end else if (expired) begin
          next_state = S_IDLE;
        end
      end
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic (values to be registered for the coming cycle)
  always_comb begin
    n_ready   = (next_state == S_IDLE);
    n_busy    = (next_state != S_IDLE);
    n_read    = 1'b0;
    n_adr1    = '0;
    n_adr2    = '0;
    n_aluop   = '0;
    n_write   = 1'b0;
    n_wadr    = '0;
    n_illegal = (next_state == S_ILL);
    n_start   = (state == S_READ) && (next_state == S_EXEC);
    n_timeout = (state == S_EXEC) && (next_state == S_IDLE);
    if ((next_state == S_READ) || (next_state == S_EXEC)) begin
      n_read  = 1'b1;
      n_adr1  = src1_f;
      n_adr2  = src2_f;
      n_aluop = op_f;
    end
    if (next_state == S_WB) begin
      n_write = 1'b1;
      n_wadr  = dst_f;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  localparam int P_IDLE = 0;
  localparam int P_ILL  = 1;
  localparam int P_READ = 2;
  localparam int P_EXEC = 3;
  localparam int P_WB   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              instr_valid = 1'b0;
  logic [19:0]       instr = '0;
  logic              alu_done = 1'b0;
  logic              instr_ready, read, alu_start, write, busy, illegal, alu_timeout;
  logic [ADDR_W-1:0] read_adr1, read_adr2, write_adr;
  logic [1:0]        aluop;
  logic [CNT_W-1:0]  retired;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .read(read), .read_adr1(read_adr1), .read_adr2(read_adr2),
    .aluop(aluop), .alu_start(alu_start), .alu_done(alu_done),
    .write(write), .write_adr(write_adr),
    .busy(busy), .illegal(illegal), .alu_timeout(alu_timeout), .retired(retired)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Transaction-level model: one in-flight instruction, timed from its accept edge.
  bit         active = 0;
  int         t_acc = 0;
  logic [1:0] m_op;
  int         m_dst, m_s1, m_s2;
  int         m_len;
  bit         m_to;
  logic [7:0] m_ret = '0;
  int         acc_cnt = 0;
  int         cur_delay = 1;
  int         dq[$];

  // ALU responder
  int pend = 0;
  bit stray = 0;

  // Event monitor
  int n_wr, n_st, n_il, n_to, n_rd, last_wr, last_to, last_acc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int phase_of(input int n);
    int k;
    if (!active) return P_IDLE;
    k = n - t_acc;
    if (m_op == 2'b11) return (k == 1) ? P_ILL : P_IDLE;
    if (k == 1) return P_READ;
    if (k >= 2 && k <= 1 + m_len) return P_EXEC;
    if (k == 2 + m_len && !m_to) return P_WB;
    return P_IDLE;
  endfunction

  always @(posedge clk) begin
    int prev;
    prev = cyc;
    cyc = cyc + 1;
    if (reset) begin
      active = 0;
      m_ret = '0;
      dq.delete();
    end else begin
      if (instr_valid && phase_of(prev) == P_IDLE) begin
        active = 1;
        t_acc  = prev;
        m_op   = instr[19:18];
        m_dst  = int'(instr[17:12]);
        m_s1   = int'(instr[11:6]);
        m_s2   = int'(instr[5:0]);
        m_to   = !(cur_delay >= 1 && cur_delay <= TIMEOUT - 1);
        m_len  = m_to ? TIMEOUT : cur_delay + 1;
        if (m_op != 2'b11) dq.push_back(cur_delay);
        acc_cnt++;
      end
      if (phase_of(cyc) == P_WB) m_ret = m_ret + 8'd1;
    end
  end

  // ALU: alu_done rises 'delay' cycles after the cycle in which alu_start is seen.
  always @(posedge clk) begin
    bit pulse;
    #2;
    pulse = 0;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) pulse = 1;
      end
      if (alu_start && dq.size() > 0) pend = dq.pop_front();
    end
    alu_done = pulse | stray;
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    int ph, k;
    bit to_exp;
    #1;
    if (chk_en) begin
      ph = phase_of(cyc);
      k  = cyc - t_acc;
      to_exp = active && (m_op != 2'b11) && m_to && (k == 2 + m_len);
      chk("instr_ready", instr_ready, ph == P_IDLE);
      chk("busy", busy, ph != P_IDLE);
      chk("read", read, ph == P_READ || ph == P_EXEC);
      chk("write", write, ph == P_WB);
      chk("alu_start", alu_start, ph == P_EXEC && k == 2);
      chk("illegal", illegal, ph == P_ILL);
      chk("alu_timeout", alu_timeout, to_exp);
      chk("retired", retired, m_ret);
      if (ph == P_READ || ph == P_EXEC) begin
        chk("read_adr1", read_adr1, m_s1);
        chk("read_adr2", read_adr2, m_s2);
        chk("aluop", aluop, m_op);
      end else if (ph == P_IDLE) begin
        chk("idle_adr1", read_adr1, 0);
        chk("idle_adr2", read_adr2, 0);
        chk("idle_aluop", aluop, 0);
        chk("idle_write_adr", write_adr, 0);
      end else if (ph == P_WB) begin
        chk("write_adr", write_adr, m_dst);
      end
      n_wr += int'(write);
      n_st += int'(alu_start);
      n_il += int'(illegal);
      n_to += int'(alu_timeout);
      n_rd += int'(read);
      if (write) last_wr = cyc;
      if (alu_timeout) last_to = cyc;
    end
  end

  task automatic clear_counts();
    n_wr = 0; n_st = 0; n_il = 0; n_to = 0; n_rd = 0; last_wr = -1; last_to = -1;
  endtask

  // Present an instruction and leave instr_valid high; returns after the accept edge.
  task automatic send(input int op, input int dst, input int s1, input int s2, input int d);
    int start_cnt;
    instr = {op[1:0], dst[5:0], s1[5:0], s2[5:0]};
    cur_delay = d;
    instr_valid = 1'b1;
    start_cnt = acc_cnt;
    for (int i = 0; i < 100 && acc_cnt == start_cnt; i++) @(negedge clk);
    chk("accept_within_bound", int'(acc_cnt != start_cnt), 1);
    last_acc = t_acc;
  endtask

  task automatic drop();
    instr_valid = 1'b0;
    instr = 20'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && phase_of(cyc) != P_IDLE; i++) @(negedge clk);
    chk("idle_within_bound", phase_of(cyc), P_IDLE);
    @(negedge clk);
  endtask

  initial begin
    int a1, a2;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_retired", retired, 0);
    chk("rst_busy", busy, 0);

    // add, 1-cycle ALU
    clear_counts();
    send(0, 5, 1, 2, 1); drop(); wait_idle();
    chk("add_wb_latency", last_wr - last_acc, 4);
    chk("add_writes", n_wr, 1);
    chk("add_starts", n_st, 1);
    chk("add_retired", retired, 1);

    // back-to-back sub then add with instr_valid held
    clear_counts();
    send(1, 7, 3, 4, 1); a1 = last_acc;
    send(0, 9, 10, 11, 1); a2 = last_acc;
    drop(); wait_idle();
    chk("b2b_accept_gap", a2 - a1, 5);
    chk("b2b_second_wb", last_wr - a1, 9);
    chk("b2b_writes", n_wr, 2);
    chk("b2b_retired", retired, 3);

    // mul, done 3 cycles after start
    clear_counts();
    send(2, 12, 13, 14, 3); drop(); wait_idle();
    chk("mul_wb_latency", last_wr - last_acc, 6);
    chk("mul_read_cycles", n_rd, 5);
    chk("mul_starts", n_st, 1);
    chk("mul_writes", n_wr, 1);
    chk("mul_retired", retired, 4);

    // illegal opcode
    clear_counts();
    send(3, 20, 21, 22, 1); drop(); wait_idle();
    chk("ill_pulses", n_il, 1);
    chk("ill_reads", n_rd, 0);
    chk("ill_writes", n_wr, 0);
    chk("ill_retired", retired, 4);

    // ALU never finishes
    clear_counts();
    send(0, 30, 31, 32, 0); drop(); wait_idle();
    chk("to_pulses", n_to, 1);
    chk("to_time", last_to - last_acc, 2 + TIMEOUT);
    chk("to_writes", n_wr, 0);
    chk("to_retired", retired, 4);

    // done in the last allowed EXEC cycle completes; one cycle later aborts
    clear_counts();
    send(1, 33, 34, 35, TIMEOUT - 1); drop(); wait_idle();
    chk("edge_done_wb", last_wr - last_acc, 2 + TIMEOUT);
    chk("edge_done_to", n_to, 0);
    clear_counts();
    send(1, 36, 37, 38, TIMEOUT); drop(); wait_idle();
    repeat (3) @(negedge clk);
    chk("late_done_to", n_to, 1);
    chk("late_done_writes", n_wr, 0);
    chk("late_done_retired", retired, 5);

    // stray alu_done while idle
    stray = 1; @(negedge clk); @(negedge clk); stray = 0;
    repeat (2) @(negedge clk);

    // reset during EXEC
    clear_counts();
    send(2, 40, 41, 42, 10); drop();
    for (int i = 0; i < 20 && n_st == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("rst_exec_ready", instr_ready, 1);
    chk("rst_exec_read", read, 0);
    chk("rst_exec_retired", retired, 0);
    repeat (12) @(negedge clk);
    chk("rst_exec_writes", n_wr, 0);
    send(0, 43, 44, 45, 2); drop(); wait_idle();
    chk("post_rst_retired", retired, 1);

    // 256 retirements wrap the counter
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    clear_counts();
    for (int i = 0; i < 256; i++) send(i % 3, i % 64, (i + 1) % 64, (i + 2) % 64, 1);
    drop(); wait_idle();
    chk("wrap_writes", n_wr, 256);
    chk("wrap_retired", retired, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
